// File: rtl/numero_source_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | numero_source_pkg : shared types for the pulse-train source/generator |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package numero_source_pkg;

    localparam int SYM_W = 2;

    // Source-side handshake sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IN_REL   = 3'd1,
        LOAD     = 3'd2,
        WAIT_RFD = 3'd3,
        ACK      = 3'd4,
        DONE_CHK = 3'd5
    } state_t;

    // Downstream pulse-train generator states
    typedef enum logic [1:0] {
        G_IDLE     = 2'd0,
        G_PULSE    = 2'd1,
        G_WAIT_DAV = 2'd2
    } gen_state_t;

    function automatic int idx_width(input int nsym);
        return (nsym > 1) ? $clog2(nsym) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/numero_sym_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | numero_sym_mux : picks symbol idx of a word, index 0 = MSB symbol     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module numero_sym_mux
    import numero_source_pkg::*;
#(
    parameter int NSYM  = 4,
    parameter int IDX_W = 2
) (
    input  logic [SYM_W*NSYM-1:0] word_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [SYM_W-1:0]      sym_o
);

    always_comb begin
        sym_o = '0;
        for (int k = 0; k < NSYM; k++) begin
            if (idx_i == IDX_W'(NSYM - 1 - k)) begin
                sym_o = word_i[SYM_W*k +: SYM_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/numero_source.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | numero_source : splits a host word into 2-bit symbols and hands each  |
// | to the pulse-train generator over a four-phase dav_/rfd handshake.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module numero_source
    import numero_source_pkg::*;
#(
    parameter int NSYM = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  byte_dav_,
    input  logic [SYM_W*NSYM-1:0] byte_i,
    output logic                  byte_rfd,
    input  logic                  rfd,
    output logic                  dav_,
    output logic [SYM_W-1:0]      numero,
    output logic                  busy
);

    localparam int IDX_W = idx_width(NSYM);

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [SYM_W*NSYM-1:0]   word_q;
    logic                    byte_rfd_q;
    logic                    dav_q;
    logic [SYM_W-1:0]        numero_q;
    logic                    busy_q;
    logic [SYM_W-1:0]        w_sym;

    numero_sym_mux #(
        .NSYM  (NSYM),
        .IDX_W (IDX_W)
    ) u_sym_mux (
        .word_i (word_q),
        .idx_i  (idx_q),
        .sym_o  (w_sym)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            byte_rfd_q <= 1'b1;
            dav_q      <= 1'b1;
            numero_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    byte_rfd_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (!byte_dav_) begin
                        word_q     <= byte_i;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        byte_rfd_q <= 1'b0;
                        state_q    <= IN_REL;
                    end
                end
                IN_REL: begin
                    // Downstream stays quiet until the host lets go of dav_
                    if (byte_dav_) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // numero settles a full cycle before dav_ can fall
                    numero_q <= w_sym;
                    state_q  <= WAIT_RFD;
                end
                WAIT_RFD: begin
                    if (rfd) begin
                        dav_q   <= 1'b0;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (!rfd) begin
                        dav_q   <= 1'b1;
                        state_q <= DONE_CHK;
                    end
                end
                DONE_CHK: begin
                    if (idx_q == IDX_W'(NSYM - 1)) begin
                        busy_q     <= 1'b0;
                        byte_rfd_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= LOAD;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    dav_q   <= 1'b1;
                end
            endcase
        end
    end

    assign byte_rfd = byte_rfd_q;
    assign dav_     = dav_q;
    assign numero   = numero_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire
